// File: rtl/systolic_mm_pkg.sv
// Shared state encoding and sizing helpers for the systolic matmul stream front-end.
package systolic_mm_pkg;

  localparam int N_DEF = 3;
  localparam int ELEMS = N_DEF * N_DEF;
  localparam int IDX_W = $clog2(2 * ELEMS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mm_state_e;

  function automatic int elems(input int n);
    return n * n;
  endfunction

  function automatic int idx_w(input int n);
    return $clog2(2 * n * n);
  endfunction

endpackage

// File: rtl/systolic_mm_out_ser.sv
// C result capture buffer and row-major valid/ready serialiser with out_last.
module systolic_mm_out_ser
  import systolic_mm_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                capture,
  input  logic                                active,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mm_matrix_c,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic                                last_hs,
  output logic                                drained
);

  localparam int NE = elems(N);
  localparam int JW = (NE > 1) ? $clog2(NE) : 1;

  // Flat row-major view: entry r*N+c is element [r][c].
  logic [NE-1:0][DATA_WIDTH-1:0] c_q;
  logic [JW-1:0]                 j_q;
  logic                          drained_q;
  logic                          j_last;

  assign j_last    = (j_q == JW'(NE - 1));
  assign out_valid = active && !drained_q;
  assign out_data  = c_q[j_q];
  assign out_last  = out_valid && j_last;
  assign last_hs   = out_last && out_ready;
  assign drained   = drained_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q       <= '0;
      j_q       <= '0;
      drained_q <= 1'b0;
    end else if (capture) begin
      c_q       <= mm_matrix_c;
      j_q       <= '0;
      drained_q <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (j_last) begin
        j_q       <= '0;
        drained_q <= 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_mm_stream_ctrl.sv
// Stream front-end for the N x N systolic multiplier: load A/B, run, drain C.
// Optional RUN watchdog enabled by defining SYS_MM_TIMEOUT_EN.
//
// state    | meaning
// ST_LOAD  | accepting A then B elements into operand registers
// ST_RUN   | mm_start held high, waiting for mm_done
// ST_DRAIN | serialising captured C; waits for mm_done low before LOAD
module systolic_mm_stream_ctrl
  import systolic_mm_pkg::*;
#(
  parameter int N              = N_DEF,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic                                mm_start,
  input  logic                                mm_done,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mm_matrix_a,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mm_matrix_b,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mm_matrix_c,
  output logic                                timeout_err
);

  localparam int            NE     = elems(N);
  localparam int            KW     = idx_w(N);
  localparam logic [KW-1:0] K_LAST = KW'(2 * NE - 1);

  mm_state_e state_q, state_d;
  logic [KW-1:0]                   k_q;
  logic [2*NE-1:0][DATA_WIDTH-1:0] ops_q;
  logic start_q;
  logic in_fire, load_done, capture, last_hs, drained, to_fire;

  assign in_ready    = (state_q == ST_LOAD) && !reset;
  assign in_fire     = in_valid && in_ready;
  assign load_done   = in_fire && (k_q == K_LAST);
  assign capture     = (state_q == ST_RUN) && mm_done;
  assign busy        = (state_q != ST_LOAD);
  assign mm_start    = start_q;
  // Lower half of the operand store is A, upper half B, both row-major.
  assign mm_matrix_a = ops_q[NE-1:0];
  assign mm_matrix_b = ops_q[2*NE-1:NE];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:  if (load_done) state_d = ST_RUN;
      ST_RUN: begin
        if (mm_done)      state_d = ST_DRAIN;
        else if (to_fire) state_d = ST_LOAD;
      end
      ST_DRAIN: if ((last_hs || drained) && !mm_done) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      ops_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == ST_RUN);
      if (in_fire) begin
        ops_q[k_q] <= in_data;
        k_q        <= load_done ? '0 : k_q + 1'b1;
      end
    end
  end

`ifdef SYS_MM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          to_err_q;

  // Down-counter loaded on RUN entry; terminal count with no done is a timeout.
  assign to_fire     = (state_q == ST_RUN) && !mm_done && (to_cnt_q == '0);
  assign timeout_err = to_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state_q == ST_LOAD && state_d == ST_RUN)
        to_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (state_q == ST_RUN && to_cnt_q != '0)
        to_cnt_q <= to_cnt_q - 1'b1;
      if (to_fire)
        to_err_q <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  systolic_mm_out_ser #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_ser (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .active      (state_q == ST_DRAIN),
    .mm_matrix_c (mm_matrix_c),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .last_hs     (last_hs),
    .drained     (drained)
  );

endmodule

// File: tb/tb_systolic_mm_stream_ctrl.sv
// Directed bench for systolic_mm_stream_ctrl with a behavioural multiplier model.
module tb_systolic_mm_stream_ctrl;

  localparam int N  = 3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic mm_done = 1'b0;
  logic [N-1:0][N-1:0][DW-1:0] mm_matrix_c = '0;
  logic in_ready, out_valid, out_last, busy, mm_start, timeout_err;
  logic [DW-1:0] out_data;
  logic [N-1:0][N-1:0][DW-1:0] mm_matrix_a, mm_matrix_b;

  int checks = 0;
  int errors = 0;
  bit hold_done = 1'b0;
  bit model_en = 1'b1;
  int mcnt = 0;

  logic [DW-1:0] job [18];
  logic [DW-1:0] exp_c [9];
  logic [DW-1:0] special [9] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h1234,
                                 16'hABCD, 16'h0000, 16'h5555, 16'hAAAA};

  always #5 clk = ~clk;

  systolic_mm_stream_ctrl #(.N(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .mm_start(mm_start), .mm_done(mm_done),
    .mm_matrix_a(mm_matrix_a), .mm_matrix_b(mm_matrix_b), .mm_matrix_c(mm_matrix_c),
    .timeout_err(timeout_err)
  );

  function automatic logic [N-1:0][N-1:0][DW-1:0] matmul(
      input logic [N-1:0][N-1:0][DW-1:0] a, input logic [N-1:0][N-1:0][DW-1:0] b);
    logic [N-1:0][N-1:0][DW-1:0] r;
    int acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(a[i][k]) * int'(b[k][j]);
        r[i][j] = acc[DW-1:0];
      end
    return r;
  endfunction

  // Multiplier model: done two cycles after start, held while start is high or hold_done.
  always @(negedge clk) begin
    if (reset) begin
      mm_done = 1'b0;
      mcnt = 0;
    end else if (!mm_done) begin
      if (mm_start && model_en) begin
        if (mcnt == 2) begin
          mm_matrix_c = matmul(mm_matrix_a, mm_matrix_b);
          mm_done = 1'b1;
          mcnt = 0;
        end else mcnt++;
      end else mcnt = 0;
    end else if (!mm_start && !hold_done) begin
      mm_done = 1'b0;
    end
  end

  // 0: A=1..9, B=all 2   1: A=2I, B=1..9   2: A=I, B=special values
  task automatic set_job(input int pat);
    for (int i = 0; i < 9; i++) begin
      case (pat)
        0: begin job[i] = DW'(i + 1); job[9+i] = 16'd2;
                 exp_c[i] = (i < 3) ? 16'd12 : (i < 6) ? 16'd30 : 16'd48; end
        1: begin job[i] = (i % 4 == 0) ? 16'd2 : 16'd0; job[9+i] = DW'(i + 1);
                 exp_c[i] = DW'(2 * (i + 1)); end
        default: begin job[i] = (i % 4 == 0) ? 16'd1 : 16'd0; job[9+i] = special[i];
                 exp_c[i] = special[i]; end
      endcase
    end
  endtask

  task automatic send_job(input bit gaps);
    int waitc;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data  = job[i];
      waitc = 0;
      while (in_ready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
      if (in_ready !== 1'b1) begin
        checks++; errors++;
        $display("FAIL in_accept elem %0d got in_ready=%b want 1 within 50 cycles", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      if (i == 17) begin
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("FAIL mm_start_early got %b want 0", mm_start); end
      end
      @(negedge clk);
      if (i == 17) begin
        in_valid = 1'b0;
        checks++;
        if (mm_start !== 1'b1) begin errors++; $display("FAIL mm_start_rise got %b want 1", mm_start); end
      end else if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic collect(input int count, input int stall_at, input int stall_len);
    int idx = 0, cyc = 0, st = 0;
    logic exp_last;
    while (idx < count && cyc < 300) begin
      out_ready = !(idx == stall_at && st < stall_len);
      if (out_valid === 1'b1) begin
        exp_last = (idx == 8);
        checks++;
        if (out_data !== exp_c[idx]) begin
          errors++; $display("FAIL c_data[%0d] got %0d want %0d", idx, out_data, exp_c[idx]);
        end
        checks++;
        if (out_last !== exp_last) begin
          errors++; $display("FAIL c_last[%0d] got %b want %b", idx, out_last, exp_last);
        end
        if (!out_ready) st++;
        else idx++;
      end else if (st > 0 && st < stall_len) begin
        checks++; errors++;
        $display("FAIL stall_valid[%0d] got out_valid=%b want 1", idx, out_valid);
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < count) begin
      checks++; errors++;
      $display("FAIL c_count got %0d want %0d elements", idx, count);
    end
  endtask

  task automatic check_idle(input string tag);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got busy=%b in_ready=%b out_valid=%b want 0 1 0", tag, busy, in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL rst_mm_start got %b want 0", mm_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    checks++; if (mm_matrix_a !== '0) begin errors++; $display("FAIL rst_a got %h want 0", mm_matrix_a); end
    checks++; if (mm_matrix_b !== '0) begin errors++; $display("FAIL rst_b got %h want 0", mm_matrix_b); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_multiply;
    logic [N-1:0][N-1:0][DW-1:0] ea, eb;
    set_job(0);
    for (int i = 0; i < 9; i++) begin
      ea[i/3][i%3] = job[i];
      eb[i/3][i%3] = job[9+i];
    end
    send_job(1'b0);
    checks++; if (mm_matrix_a !== ea) begin errors++; $display("FAIL op_a got %h want %h", mm_matrix_a, ea); end
    checks++; if (mm_matrix_b !== eb) begin errors++; $display("FAIL op_b got %h want %h", mm_matrix_b, eb); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL run_flags got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    collect(9, -1, 0);
    check_idle("multiply");
  endtask

  task automatic test_input_gaps;
    set_job(0);
    send_job(1'b1);
    collect(9, -1, 0);
    check_idle("gaps");
  endtask

  task automatic test_backpressure;
    set_job(0);
    send_job(1'b0);
    collect(9, 3, 5);
    check_idle("backpressure");
  endtask

  task automatic test_stuck_done;
    int waitc;
    hold_done = 1'b1;
    set_job(0);
    send_job(1'b0);
    collect(9, -1, 0);
    set_job(2);
    in_valid = 1'b1;
    in_data  = job[0];
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stuck_hold[%0d] got in_ready=%b out_valid=%b busy=%b want 0 0 1", i, in_ready, out_valid, busy);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 hold_done = 1'b0;
    @(negedge clk);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 10) begin @(negedge clk); waitc++; end
    checks++;
    if (in_ready !== 1'b1 || waitc != 1) begin
      errors++; $display("FAIL stuck_release got in_ready=%b after %0d cycles want 1 after 1", in_ready, waitc);
    end
    send_job(1'b0);
    collect(9, -1, 0);
    check_idle("back_to_back");
  endtask

  task automatic test_reset_mid_drain;
    set_job(0);
    send_job(1'b0);
    collect(4, -1, 0);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    checks++; if (mm_start !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL mid_rst_start_last got %b %b want 0 0", mm_start, out_last);
    end
    checks++; if (mm_matrix_a !== '0 || mm_matrix_b !== '0) begin
      errors++; $display("FAIL mid_rst_ops got %h %h want 0", mm_matrix_a, mm_matrix_b);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_job(1);
    send_job(1'b0);
    collect(9, -1, 0);
    check_idle("after_reset");
  endtask

`ifdef SYS_MM_TIMEOUT_EN
  task automatic test_timeout;
    model_en = 1'b0;
    set_job(0);
    send_job(1'b0);
    repeat (63) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || mm_start !== 1'b1) begin
      errors++; $display("FAIL to_early got err=%b start=%b want 0 1", timeout_err, mm_start);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || mm_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL to_fire got err=%b start=%b in_ready=%b want 1 0 1", timeout_err, mm_start, in_ready);
    end
    checks++;
    if (mm_matrix_a[2][2] !== 16'd9 || out_valid !== 1'b0) begin
      errors++; $display("FAIL to_retain got a22=%0d out_valid=%b want 9 0", mm_matrix_a[2][2], out_valid);
    end
    model_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_multiply();
    test_input_gaps();
    test_backpressure();
    test_stuck_done();
    test_reset_mid_drain();
`ifdef SYS_MM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_mm_stream_ctrl.md
Name: systolic_mm_stream_ctrl

Overview:
Streaming host-side front-end for the N x N systolic matrix multiplier; it drives the multiplier's start/done handshake from the initiator side.
- Collects A then B elements from a valid/ready input stream into local N x N registers, presented in parallel to the multiplier.
- Holds mm_start until mm_done, captures the parallel result matrix, then serialises C row-major onto a valid/ready output stream.

Parameters:
N, 3, matrix dimension (N x N)
DATA_WIDTH, 16, element width for A, B and C
TIMEOUT_CYCLES, 64, watchdog limit in RUN (used only with SYS_MM_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input element valid
in_ready  output  1  controller accepts an input element
in_data  input  DATA_WIDTH  element: A row-major (N*N), then B row-major (N*N)
out_valid  output  1  C element valid
out_ready  input  1  downstream accepts a C element
out_data  output  DATA_WIDTH  C element, row-major
out_last  output  1  high with the final C element (index N*N-1)
busy  output  1  high in RUN and DRAIN
mm_start  output  1  level start to multiplier
mm_done  input  1  multiplier result-ready
mm_matrix_a  output  [N][N] x DATA_WIDTH  A operand registers
mm_matrix_b  output  [N][N] x DATA_WIDTH  B operand registers
mm_matrix_c  input  [N][N] x DATA_WIDTH  multiplier result
timeout_err  output  1  sticky watchdog flag (SYS_MM_TIMEOUT_EN only)

Behaviour:
- Reset is asynchronous, active-high, on clock clk. While reset is asserted:
  - state = LOAD; all counters 0.
  - in_ready = 0, out_valid = 0, out_last = 0, mm_start = 0, busy = 0, timeout_err = 0.
  - mm_matrix_a, mm_matrix_b and the C capture buffer are all 0.
- States: LOAD, RUN, DRAIN.
- LOAD:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready; each transfer writes element index k, then k increments.
  - k < N*N writes mm_matrix_a[k/N][k%N]; k >= N*N writes mm_matrix_b[(k-N*N)/N][(k-N*N)%N].
  - k width is $clog2(2*N*N).
  - The transfer at k = 2*N*N-1 moves the FSM to RUN; k wraps to 0. mm_start is registered high the next cycle.
  - Gaps in in_valid stall loading without losing state.
- RUN:
  - in_ready = 0 and input is ignored; mm_start = 1.
  - On the first cycle with mm_done = 1: mm_matrix_c is captured into the local buffer, mm_start is deasserted (registered), and the FSM moves to DRAIN.
  - Operands stay stable throughout RUN.
- DRAIN:
  - mm_start = 0; out_valid = 1; out_data = buffer[j/N][j%N].
  - j advances on out_valid && out_ready. out_data and out_last must stay stable while out_ready = 0.
  - out_last = 1 when j = N*N-1.
  - On the final handshake the FSM returns to LOAD, but only once mm_done = 0.
  - If mm_done is still 1 at the final handshake: out_valid drops, the FSM stays in DRAIN until mm_done falls, and in_ready stays 0 meanwhile.
- Data widths: values pass through unmodified; no arithmetic is applied to data.
- Reset mid-operation: all state aborts immediately to the reset values; partial loads are discarded.
- Simultaneous events: mm_done asserting in the same cycle mm_start rises is accepted as done.

Optional Feature:
Macro SYS_MM_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN, cleared on entry to RUN.
  - If it reaches TIMEOUT_CYCLES without mm_done: timeout_err is set (sticky until reset), mm_start drops, and the FSM returns to LOAD with operands retained and nothing drained.
- Undefined: no counter; timeout_err is tied to 0; RUN waits indefinitely.

Decomposition:
- Shared package systolic_mm_pkg: state enum (LOAD, RUN, DRAIN) and the localparams ELEMS = N*N and IDX_W = $clog2(2*N*N).
- One natural sub-module, systolic_mm_out_ser: the C capture buffer plus the valid/ready serialiser with out_last. The FSM and load path stay in the top.

Test Plan:
- Functional multiply, N=3: stream A = 1..9 row-major, then B = all 2, with a behavioural multiplier model → out_data = 12,12,12,30,30,30,48,48,48; out_last only on the 9th; busy low afterwards.
- Input gaps: in_valid toggles 1/0 every cycle over 18 elements → identical C; mm_start rises exactly one cycle after the 18th accepted element.
- Output backpressure: out_ready low for 5 cycles at element 4 → out_data holds 30 and out_valid stays 1; sequence unchanged.
- Stuck done: model holds mm_done high for 3 cycles after the last drain → no in_ready until mm_done falls; the next job's first element is then accepted.
- Reset mid-DRAIN after 4 outputs → all outputs return to reset values at once; a fresh 18-element load produces a full correct 9-element C.
- With SYS_MM_TIMEOUT_EN, TIMEOUT_CYCLES = 64 and mm_done tied 0 → timeout_err high 64 cycles after entering RUN, mm_start low, in_ready high the following cycle.
